// File: rtl/avl_mem_tester_param.sv
// avl_mem_tester_param: Avalon-MM burst write/readback memory tester; `define TESTER_ERR_CAPTURE_EN adds err_count/first_err_addr
module avl_mem_tester_param #(
   parameter int          DATA_W     = 64,
   parameter int          ADDR_W     = 26,
   parameter int          SIZE_W     = 2,
   parameter int          BURST_LEN  = 2,
   parameter int          NUM_BURSTS = 1024,
   parameter logic [31:0] LFSR_SEED  = 32'h1ACE_B00C
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [1:0]          mode,
   output logic                busy,
   input  logic                avl_ready,
   output logic [ADDR_W-1:0]   avl_addr,
   output logic [SIZE_W-1:0]   avl_size,
   output logic [DATA_W-1:0]   avl_wdata,
   input  logic [DATA_W-1:0]   avl_rdata,
   output logic                avl_write_req,
   output logic                avl_read_req,
   input  logic                avl_rdata_valid,
   output logic [DATA_W/8-1:0] avl_be,
   output logic                avl_burstbegin,
   output logic [DATA_W-1:0]   pnf_per_bit,
   output logic [DATA_W-1:0]   pnf_per_bit_persist,
   output logic                pass,
   output logic                fail,
`ifdef TESTER_ERR_CAPTURE_EN
   output logic [31:0]         err_count,
   output logic [ADDR_W-1:0]   first_err_addr,
`endif
   output logic                test_complete
);
   localparam int TOTAL = NUM_BURSTS * BURST_LEN;
   localparam int CW = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(TOTAL - 1);
   localparam logic [CW-1:0] LAST_BURST = CW'(NUM_BURSTS - 1);
   localparam logic [CW-1:0] ALL_BEATS = CW'(TOTAL);
   localparam logic [SIZE_W-1:0] LAST_IN_BURST = SIZE_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN);
   localparam logic [31:0] POLY = 32'h8020_0003;

   typedef enum logic [2:0] {IDLE, WRITE, READ, RDWAIT, DONE} state_t;

   state_t            state;
   logic [1:0]        mode_r;
   logic [CW-1:0]     wr_idx, rd_cnt, chk_idx;
   logic [SIZE_W-1:0] bcnt;
   logic [31:0]       wr_lfsr, chk_lfsr;
   logic              chk_last, cmp_en, can_start;
   logic [DATA_W-1:0] pnf_d;

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      return (l >> 1) ^ (l[0] ? POLY : 32'h0);
   endfunction

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [CW-1:0] i, input logic [31:0] l);
      logic [DATA_W-1:0] r;
      for (int k = 0; k < DATA_W; k++) r[k] = l[k % 32];
      return m == 2'd0 ? r : m == 2'd1 ? DATA_W'(i) : m == 2'd2 ? DATA_W'(1) << (int'(i) % DATA_W) :
             i[0] ? {DATA_W/8{8'hAA}} : {DATA_W/8{8'h55}};
   endfunction

   assign avl_size = SIZE_W'(BURST_LEN);
   assign avl_be = '1;

   // compare incoming read beats against the regenerated pattern
   always_comb begin
      can_start = start && (state == IDLE || state == DONE);
      cmp_en = avl_rdata_valid && (state == READ || state == RDWAIT) && chk_idx != ALL_BEATS;
      pnf_d = ~(avl_rdata ^ pattern(mode_r, chk_idx, chk_lfsr));
   end

   // test sequencer: write all bursts, read them back, check every beat
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         mode_r <= '0;
         wr_idx <= '0;
         rd_cnt <= '0;
         chk_idx <= '0;
         bcnt <= '0;
         wr_lfsr <= LFSR_SEED;
         chk_lfsr <= LFSR_SEED;
         chk_last <= 1'b0;
         busy <= 1'b0;
         avl_addr <= '0;
         avl_wdata <= '0;
         avl_write_req <= 1'b0;
         avl_read_req <= 1'b0;
         avl_burstbegin <= 1'b0;
         pnf_per_bit <= '1;
         pnf_per_bit_persist <= '1;
         pass <= 1'b0;
         fail <= 1'b0;
         test_complete <= 1'b0;
      end else begin
         chk_last <= cmp_en && chk_idx == LAST_BEAT;
         if (cmp_en) begin
            pnf_per_bit <= pnf_d;
            pnf_per_bit_persist <= pnf_per_bit_persist & pnf_d;
            fail <= fail | ~&pnf_d;
            chk_idx <= chk_idx + 1'b1;
            chk_lfsr <= lfsr_step(chk_lfsr);
         end
         case (state)
            IDLE, DONE: if (start) begin
               state <= WRITE;
               mode_r <= mode;
               busy <= 1'b1;
               pass <= 1'b0;
               fail <= 1'b0;
               test_complete <= 1'b0;
               pnf_per_bit_persist <= '1;
               avl_write_req <= 1'b1;
               avl_burstbegin <= 1'b1;
               avl_addr <= '0;
               avl_wdata <= pattern(mode, '0, LFSR_SEED);
               wr_idx <= '0;
               rd_cnt <= '0;
               chk_idx <= '0;
               bcnt <= '0;
               wr_lfsr <= LFSR_SEED;
               chk_lfsr <= LFSR_SEED;
            end
            WRITE: if (avl_ready) begin
               if (wr_idx == LAST_BEAT) begin
                  state <= READ;
                  avl_write_req <= 1'b0;
                  avl_read_req <= 1'b1;
                  avl_burstbegin <= 1'b1;
                  avl_addr <= '0;
               end else begin
                  wr_idx <= wr_idx + 1'b1;
                  wr_lfsr <= lfsr_step(wr_lfsr);
                  avl_wdata <= pattern(mode_r, wr_idx + 1'b1, lfsr_step(wr_lfsr));
                  bcnt <= bcnt == LAST_IN_BURST ? '0 : bcnt + 1'b1;
                  avl_burstbegin <= bcnt == LAST_IN_BURST;
                  avl_addr <= bcnt == LAST_IN_BURST ? avl_addr + ADDR_STEP : avl_addr;
               end
            end
            READ: if (avl_ready) begin
               if (rd_cnt == LAST_BURST) begin
                  state <= RDWAIT;
                  avl_read_req <= 1'b0;
                  avl_burstbegin <= 1'b0;
               end else begin
                  rd_cnt <= rd_cnt + 1'b1;
                  avl_addr <= avl_addr + ADDR_STEP;
               end
            end
            RDWAIT: if (chk_last) begin
               state <= DONE;
               busy <= 1'b0;
               test_complete <= 1'b1;
               pass <= ~fail;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TESTER_ERR_CAPTURE_EN
   // count failing beats and remember the word address of the first one
   always_ff @(posedge clk) begin
      if (!reset_n || can_start) begin
         err_count <= '0;
         first_err_addr <= '0;
      end else if (cmp_en && !(&pnf_d)) begin
         err_count <= &err_count ? err_count : err_count + 1'b1;
         first_err_addr <= err_count == '0 ? ADDR_W'(chk_idx) : first_err_addr;
      end
   end
`endif
endmodule

// File: tb/tb_avl_mem_tester_param.sv
// tb_avl_mem_tester_param: randomized bench with ideal memory and pattern reference model
module tb_avl_mem_tester_param;
   localparam int DW = 64, AW = 26, SW = 2, BL = 2, NB = 4, NT = NB * BL;
   localparam logic [31:0] SEED = 32'h1ACE_B00C;

   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, avl_ready = 1'b0, avl_rdata_valid = 1'b0;
   logic [1:0] mode = '0;
   logic [DW-1:0] avl_rdata = '0;
   logic busy, avl_write_req, avl_read_req, avl_burstbegin, pass, fail, test_complete;
   logic [AW-1:0] avl_addr;
   logic [SW-1:0] avl_size;
   logic [DW-1:0] avl_wdata, pnf_per_bit, pnf_per_bit_persist;
   logic [DW/8-1:0] avl_be;
`ifdef TESTER_ERR_CAPTURE_EN
   logic [31:0] err_count;
   logic [AW-1:0] first_err_addr;
`endif

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   avl_mem_tester_param #(.DATA_W(DW), .ADDR_W(AW), .SIZE_W(SW), .BURST_LEN(BL), .NUM_BURSTS(NB), .LFSR_SEED(SEED)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .busy(busy), .avl_ready(avl_ready),
      .avl_addr(avl_addr), .avl_size(avl_size), .avl_wdata(avl_wdata), .avl_rdata(avl_rdata),
      .avl_write_req(avl_write_req), .avl_read_req(avl_read_req), .avl_rdata_valid(avl_rdata_valid),
      .avl_be(avl_be), .avl_burstbegin(avl_burstbegin), .pnf_per_bit(pnf_per_bit),
      .pnf_per_bit_persist(pnf_per_bit_persist), .pass(pass), .fail(fail),
`ifdef TESTER_ERR_CAPTURE_EN
      .err_count(err_count), .first_err_addr(first_err_addr),
`endif
      .test_complete(test_complete)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // expected data of beat i, by stepping the PRBS i times from the seed
   function automatic logic [63:0] ref_pat(input int m, input int i);
      logic [31:0] l;
      l = SEED;
      for (int k = 0; k < i; k++) l = l[0] ? (l >> 1) ^ 32'h8020_0003 : l >> 1;
      case (m)
         0: return {l, l};
         1: return 64'(i);
         2: return 64'(1) << (i % 64);
         default: return (i % 2) ? {8{8'hAA}} : {8{8'h55}};
      endcase
   endfunction

   int rmode = 0, cur_mode = 0, wcnt = 0, rcnt = 0, ret = 0, cyc = 0, wbase = 0, wb = 0, flip_bit = 0;
   bit model_chk = 1'b1, pnf_pend = 1'b0, stalled = 1'b0;
   logic [NT-1:0] flip_beats = '0;
   logic [63:0] mem [256];
   int rq[$];
   logic [63:0] pnf_exp, persist_exp = '1, p_wdata, d;
   logic [AW-1:0] p_addr;
   logic p_wr, p_rd, p_bb;

   // ideal memory slave: acts at negedge on what the DUT presents for the next posedge
   initial forever begin
      @(negedge clk);
      if (pnf_pend) check("pnf", pnf_per_bit, pnf_exp);
      pnf_pend = 1'b0;
      if (stalled) begin
         check("stall_addr", 64'(avl_addr), 64'(p_addr));
         check("stall_wdata", avl_wdata, p_wdata);
         check("stall_ctl", 64'({avl_write_req, avl_read_req, avl_burstbegin}), 64'({p_wr, p_rd, p_bb}));
      end
      if (rq.size() > 0 && $urandom_range(0, 3) != 0) begin
         d = mem[rq.pop_front()];
         if (ret < NT && flip_beats[ret]) d[flip_bit] = ~d[flip_bit];
         avl_rdata_valid = 1'b1;
         avl_rdata = d;
         if (model_chk) begin
            pnf_exp = ~(d ^ ref_pat(cur_mode, ret));
            persist_exp &= pnf_exp;
            pnf_pend = 1'b1;
         end
         ret++;
      end else begin
         avl_rdata_valid = 1'b0;
         avl_rdata = {$urandom, $urandom};
      end
      cyc++;
      avl_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      if (avl_write_req && avl_ready) begin
         if (avl_burstbegin) begin
            wbase = int'(avl_addr);
            wb = 0;
         end
         check("wdata", avl_wdata, ref_pat(cur_mode, wcnt));
         check("waddr", 64'(avl_addr), 64'((wcnt / BL) * BL));
         check("wburstbegin", 64'(avl_burstbegin), 64'(wcnt % BL == 0));
         mem[(wbase + wb) % 256] = avl_wdata;
         wb++;
         wcnt++;
      end
      if (avl_read_req && avl_ready) begin
         check("raddr", 64'(avl_addr), 64'(rcnt * BL));
         check("rburstbegin", 64'(avl_burstbegin), 64'(1));
         for (int b = 0; b < BL; b++) rq.push_back((int'(avl_addr) + b) % 256);
         rcnt++;
      end
      stalled = (avl_write_req || avl_read_req) && !avl_ready && reset_n;
      p_addr = avl_addr;
      p_wdata = avl_wdata;
      p_wr = avl_write_req;
      p_rd = avl_read_req;
      p_bb = avl_burstbegin;
   end

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_reqs"}, 64'({avl_write_req, avl_read_req, avl_burstbegin}), 64'(0));
      check({tag, "_addr"}, 64'(avl_addr), 64'(0));
      check({tag, "_wdata"}, avl_wdata, 64'(0));
      check({tag, "_pnf"}, pnf_per_bit, '1);
      check({tag, "_persist"}, pnf_per_bit_persist, '1);
      check({tag, "_flags"}, 64'({pass, fail, test_complete}), 64'(0));
   endtask

   task automatic begin_run(input int m, input int rm, input logic [NT-1:0] flips, input int fb);
      cur_mode = m;
      rmode = rm;
      flip_beats = flips;
      flip_bit = fb;
      wcnt = 0;
      rcnt = 0;
      ret = 0;
      persist_exp = '1;
      model_chk = 1'b1;
      rq.delete();
      mode = 2'(m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 64'(busy), 64'(1));
      check("start_flags", 64'({pass, fail, test_complete}), 64'(0));
      check("start_persist", pnf_per_bit_persist, '1);
`ifdef TESTER_ERR_CAPTURE_EN
      check("start_err_count", 64'(err_count), 64'(0));
`endif
   endtask

   task automatic finish_run(input string tag, input bit exp_pass);
      int n = 0;
      while (!test_complete && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_complete"}, 64'(test_complete), 64'(1));
      check({tag, "_pass"}, 64'(pass), 64'(exp_pass));
      check({tag, "_fail"}, 64'(fail), 64'(!exp_pass));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_persist"}, pnf_per_bit_persist, persist_exp);
      check({tag, "_counts"}, 64'({16'(wcnt), 16'(rcnt), 16'(ret)}), 64'({16'(NT), 16'(NB), 16'(NT)}));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("size_be", 64'({avl_size, avl_be}), 64'({2'(BL), 8'hFF}));
      reset_n = 1'b1;
      @(negedge clk);
      begin_run(1, 0, '0, 0);
      finish_run("addr_ready", 1'b1);
      begin_run(1, 1, '0, 0);
      finish_run("addr_stall", 1'b1);
      begin_run(0, 0, NT'(8), 5);
      @(negedge clk);
      mode = 2'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_run("prbs_flip", 1'b0);
      check("prbs_flip_bit5", 64'(pnf_per_bit_persist[5]), 64'(0));
      begin_run(3, 2, '0, 0);
      finish_run("alt_random", 1'b1);
      begin_run(2, 2, '0, 0);
      finish_run("walk_random", 1'b1);
      for (int r = 0; r < 3; r++) begin
         logic [NT-1:0] fl;
         fl = $urandom_range(0, 1) ? NT'(1) << $urandom_range(0, NT - 1) : '0;
         begin_run(int'($urandom_range(0, 3)), 2, fl, int'($urandom_range(0, 63)));
         finish_run("random_run", fl == '0);
      end
`ifdef TESTER_ERR_CAPTURE_EN
      begin_run(1, 0, NT'(8'b0110_0000), 0);
      finish_run("err_capture", 1'b0);
      check("err_count", 64'(err_count), 64'(2));
      check("first_err_addr", 64'(first_err_addr), 64'(5));
`endif
      begin_run(2, 0, '0, 0);
      for (int n = 0; n < 200 && rcnt < 2; n++) @(negedge clk);
      check("abort_in_read", 64'(avl_read_req), 64'(1));
      reset_n = 1'b0;
      model_chk = 1'b0;
      @(negedge clk);
      check_idle("abort");
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      check_idle("stale");
      rq.delete();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end
endmodule
